// File: rtl/root_uplink_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : root_uplink_arbiter
// Description : Round-robin merge of NUM_LEAVES 64-bit leaf uplinks into one
//               registered output slot tagged with the source leaf index.
//               Optional macro ROOT_UPLINK_ARB_HOLD_EN: bit 63 = "more" flag
//               that keeps the grant on one leaf until its burst ends.
// Revision    : 1.0 - initial release
// ============================================================================
module root_uplink_arbiter #(
    parameter int NUM_LEAVES = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [64*NUM_LEAVES-1:0] up_rx_data,
    input  logic [NUM_LEAVES-1:0]    up_rx_valid,
    output logic [NUM_LEAVES-1:0]    up_rx_ready,
    output logic [63:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ID_WIDTH-1:0]      out_leaf_id
);

    localparam int PAD_LEAVES = 2 ** ID_WIDTH;

    logic [PAD_LEAVES-1:0] valid_pad;
    logic [ID_WIDTH-1:0]   last_grant;
    logic [ID_WIDTH-1:0]   rr_grant;
    logic                  rr_found;
    logic [ID_WIDTH:0]     cand;
    logic [ID_WIDTH-1:0]   grant;
    logic                  grant_found;
    logic                  slot_free;
    logic                  xfer;
    logic [63:0]           grant_data;

`ifdef ROOT_UPLINK_ARB_HOLD_EN
    logic                  hold_active;
    logic [ID_WIDTH-1:0]   hold_leaf;
`endif

    // Padding to a power of two lets the candidate index have exactly ID_WIDTH bits.
    assign valid_pad = PAD_LEAVES'(up_rx_valid);
    assign slot_free = !out_valid || out_ready;

    always_comb begin
        rr_grant = '0;
        rr_found = 1'b0;
        cand     = '0;
        for (int off = 1; off <= NUM_LEAVES; off++) begin
            cand = {1'b0, last_grant} + (ID_WIDTH+1)'(off);
            if (cand >= (ID_WIDTH+1)'(NUM_LEAVES)) begin
                cand = cand - (ID_WIDTH+1)'(NUM_LEAVES);
            end
            if (!rr_found && valid_pad[cand[ID_WIDTH-1:0]]) begin
                rr_found = 1'b1;
                rr_grant = cand[ID_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        grant       = rr_grant;
        grant_found = rr_found;
`ifdef ROOT_UPLINK_ARB_HOLD_EN
        if (hold_active) begin
            grant       = hold_leaf;
            grant_found = valid_pad[hold_leaf];
        end
`endif
    end

    assign xfer = slot_free && grant_found && !reset;

    always_comb begin
        up_rx_ready = '0;
        grant_data  = '0;
        for (int i = 0; i < NUM_LEAVES; i++) begin
            if (grant == ID_WIDTH'(i)) begin
                up_rx_ready[i] = xfer;
                grant_data     = up_rx_data[i*64 +: 64];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_leaf_id <= '0;
            last_grant  <= ID_WIDTH'(NUM_LEAVES - 1);
`ifdef ROOT_UPLINK_ARB_HOLD_EN
            hold_active <= 1'b0;
            hold_leaf   <= '0;
`endif
        end else if (xfer) begin
            out_valid   <= 1'b1;
            out_data    <= grant_data;
            out_leaf_id <= grant;
`ifdef ROOT_UPLINK_ARB_HOLD_EN
            hold_active <= grant_data[63];
            hold_leaf   <= grant;
            // Rotation pointer only advances once the burst is complete.
            if (!grant_data[63]) begin
                last_grant <= grant;
            end
`else
            last_grant  <= grant;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire
